// File: rtl/data_ram.sv
// data_ram: word-organised data memory for the execute stage.
// Stores commit on the rising edge; loads are combinational from the array.
// Out-of-range or misaligned accesses raise a one-cycle o_addr_err pulse.
// Optional feature macro DATA_RAM_CLEAR_EN: when defined, a post-reset
// zero-fill sweep (CLEAR state) runs before the memory reports ready, and
// o_hold_req stalls the pipeline for the sweep's duration.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | zero-fill sweep in progress, stores ignored, reads return 0
// ST_RUN   | normal operation, stores and loads serviced
module data_ram #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_mem_we,
  input  logic [ADDR_W-1:0] i_mem_r_addr,
  input  logic [ADDR_W-1:0] i_mem_w_addr,
  input  logic [DATA_W-1:0] i_mem_w_data,
  output logic [DATA_W-1:0] o_mem_r_data,
  output logic              o_hold_req,
  output logic              o_ready,
  output logic              o_addr_err
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx;
  logic              r_ok;
  logic              w_ok;
  logic              run;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic              addr_err_nxt;

  assign r_idx = i_mem_r_addr[IDX_W+1:2];
  assign w_idx = i_mem_w_addr[IDX_W+1:2];
  assign r_ok  = (i_mem_r_addr[ADDR_W-1:IDX_W+2] == '0) && (i_mem_r_addr[1:0] == 2'b00);
  assign w_ok  = (i_mem_w_addr[ADDR_W-1:IDX_W+2] == '0) && (i_mem_w_addr[1:0] == 2'b00);

`ifdef DATA_RAM_CLEAR_EN
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] clr_idx;
  logic [IDX_W-1:0] clr_idx_nxt;

  // State and sweep counter; reset always restarts the sweep from word 0.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  // Next state and array write port selection: sweep owns the port in CLEAR.
  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    run         = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = w_idx;
    wr_data     = i_mem_w_data;
    case (state)
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_idx  = clr_idx;
        wr_data = '0;
        // Counter parks on the last index; it never wraps back to 0.
        if (clr_idx == IDX_W'(DEPTH - 1)) state_nxt = ST_RUN;
        else                              clr_idx_nxt = clr_idx + 1'b1;
      end
      ST_RUN: begin
        run   = 1'b1;
        wr_en = i_mem_we && w_ok;
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end
`else
  // No sweep: the memory is serviceable straight out of reset.
  always_comb begin
    run     = 1'b1;
    wr_en   = i_mem_we && w_ok;
    wr_idx  = w_idx;
    wr_data = i_mem_w_data;
  end
`endif

  // Array write port; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Combinational load: same-cycle read of a word being stored sees old data.
  always_comb begin
    o_mem_r_data = '0;
    if (run && r_ok) o_mem_r_data = mem[r_idx];
  end

  assign o_hold_req   = ~run;
  assign o_ready      = run;
  assign addr_err_nxt = run && (!r_ok || (i_mem_we && !w_ok));

  // Error pulse registered one edge after the offending RUN cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) o_addr_err <= 1'b0;
    else         o_addr_err <= addr_err_nxt;
  end

endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: directed plus randomized checks of data_ram (DEPTH=16)
// against a word-array reference model. Works with or without
// DATA_RAM_CLEAR_EN defined.
module tb_data_ram;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
`ifdef DATA_RAM_CLEAR_EN
  localparam int SWEEP = DEPTH;
`else
  localparam int SWEEP = 0;
`endif

  logic              i_clk;
  logic              i_reset;
  logic              i_mem_we;
  logic [ADDR_W-1:0] i_mem_r_addr;
  logic [ADDR_W-1:0] i_mem_w_addr;
  logic [DATA_W-1:0] i_mem_w_data;
  logic [DATA_W-1:0] o_mem_r_data;
  logic              o_hold_req;
  logic              o_ready;
  logic              o_addr_err;

  int tests = 0;
  int fails = 0;

  logic [31:0] model_mem [DEPTH];
  bit          known     [DEPTH];

  data_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_mem_we     (i_mem_we),
    .i_mem_r_addr (i_mem_r_addr),
    .i_mem_w_addr (i_mem_w_addr),
    .i_mem_w_data (i_mem_w_data),
    .o_mem_r_data (o_mem_r_data),
    .o_hold_req   (o_hold_req),
    .o_ready      (o_ready),
    .o_addr_err   (o_addr_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic bit addr_valid(input logic [31:0] a);
    return (a < 32'(DEPTH * 4)) && (a % 4 == 0);
  endfunction

  function automatic int addr_word(input logic [31:0] a);
    return int'(a / 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_fill(input bit zeroed);
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = '0;
      known[i]     = zeroed;
    end
  endtask

  // One RUN cycle: present inputs, check load data, clock, check error pulse.
  task automatic step(input bit we, input logic [31:0] wa, input logic [31:0] wd,
                      input logic [31:0] ra);
    bit exp_err;
    i_mem_we     = we;
    i_mem_w_addr = wa;
    i_mem_w_data = wd;
    i_mem_r_addr = ra;
    #1;
    if (!addr_valid(ra))            chk("rdata_invalid", o_mem_r_data, 32'h0);
    else if (known[addr_word(ra)])  chk("rdata", o_mem_r_data, model_mem[addr_word(ra)]);
    exp_err = !addr_valid(ra) || (we && !addr_valid(wa));
    @(posedge i_clk);
    #1;
    chk("addr_err", 32'(o_addr_err), 32'(exp_err));
    if (we && addr_valid(wa)) begin
      model_mem[addr_word(wa)] = wd;
      known[addr_word(wa)]     = 1'b1;
    end
    i_mem_we = 1'b0;
  endtask

  // Count cycles with hold asserted after reset release; loads must read 0.
  task automatic count_sweep(output int n);
    n = 0;
    i_mem_r_addr = 32'h08;
    #1;
    while (o_hold_req === 1'b1 && n < 100) begin
      chk("sweep_rdata", o_mem_r_data, 32'h0);
      chk("sweep_ready", 32'(o_ready), 32'h0);
      @(posedge i_clk);
      #1;
      n++;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0:       a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
      1:       a = 32'(DEPTH * 4) + 32'($urandom_range(0, 1000)) * 4;
      2:       a = $urandom | 32'h8000_0000;
      default: a = 32'($urandom_range(0, DEPTH - 1)) * 4;
    endcase
    return a;
  endfunction

  initial begin
    int n;
    i_reset      = 1'b1;
    i_mem_we     = 1'b0;
    i_mem_r_addr = '0;
    i_mem_w_addr = '0;
    i_mem_w_data = '0;

    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_hold",  32'(o_hold_req), 32'(SWEEP != 0));
    chk("rst_ready", 32'(o_ready),    32'(SWEEP == 0));
    chk("rst_err",   32'(o_addr_err), 32'h0);
`ifdef DATA_RAM_CLEAR_EN
    chk("rst_rdata", o_mem_r_data, 32'h0);
`endif
    i_reset = 1'b0;
    count_sweep(n);
    chk("sweep_len", 32'(n), 32'(SWEEP));
    chk("run_ready", 32'(o_ready), 32'h1);
    chk("run_hold",  32'(o_hold_req), 32'h0);
    model_fill(SWEEP != 0);

    // Every word reads zero after the sweep (only when the sweep exists).
    for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0, 32'h0, 32'(i * 4));

    // First-cycle store then load.
    step(1'b1, 32'h04, 32'h0BAD_F00D, 32'h04);
    step(1'b0, 32'h00, 32'h0, 32'h04);
    // Same-cycle read returns old word; new value next cycle.
    step(1'b1, 32'h08, 32'hDEAD_BEEF, 32'h08);
    step(1'b0, 32'h00, 32'h0, 32'h08);
    // Out-of-range store: error pulse, no aliasing onto word 0.
    step(1'b1, 32'h00, 32'h1111_2222, 32'h00);
    step(1'b1, 32'h40, 32'h1234_5678, 32'h00);
    step(1'b0, 32'h00, 32'h0, 32'h00);
    step(1'b0, 32'h00, 32'h0, 32'h00);
    // Misaligned load and store.
    step(1'b0, 32'h00, 32'h0, 32'h06);
    step(1'b1, 32'h0A, 32'hCAFE_0000, 32'h08);
    step(1'b0, 32'h00, 32'h0, 32'h08);
    // Both invalid in one cycle: single pulse, cleared afterwards.
    step(1'b1, 32'h41, 32'h5555_5555, 32'h43);
    step(1'b0, 32'h00, 32'h0, 32'h0C);

    for (int k = 0; k < 300; k++)
      step(1'($urandom_range(0, 1)), rand_addr(), $urandom, rand_addr());

    // Reset mid-sweep must restart the full sweep and re-zero the array.
    step(1'b1, 32'h08, 32'hA5A5_5A5A, 32'h00);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
`ifdef DATA_RAM_CLEAR_EN
    repeat (7) @(posedge i_clk);
    #1;
    chk("mid_hold_pre", 32'(o_hold_req), 32'h1);
    i_reset = 1'b1;
    #1;
    chk("mid_hold_rst", 32'(o_hold_req), 32'h1);
    chk("mid_err_rst",  32'(o_addr_err), 32'h0);
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
`endif
    count_sweep(n);
    chk("resweep_len", 32'(n), 32'(SWEEP));
    chk("resweep_ready", 32'(o_ready), 32'h1);
`ifdef DATA_RAM_CLEAR_EN
    model_fill(1'b1);
`endif
    step(1'b0, 32'h00, 32'h0, 32'h08);
    step(1'b1, 32'h3C, 32'h7777_8888, 32'h3C);
    step(1'b0, 32'h00, 32'h0, 32'h3C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
